// File: rtl/ram_port_arbiter.sv
// Round-robin arbiter between NREQ requesters and one RAM port, with a
// draining testbench takeover. Grants are registered; the ram_* mux is combinational.
module ram_port_arbiter #(
  parameter int NREQ = 2,
  parameter int AW   = 32,
  parameter int DW   = 32
) (
  input  logic              CLK,
  input  logic              nRST,
  input  logic              tbCTRL,
  input  logic              tb_wen,
  input  logic              tb_ren,
  input  logic [AW-1:0]     tb_addr,
  input  logic [DW-1:0]     tb_store,
  input  logic [NREQ-1:0]   req_wen,
  input  logic [NREQ-1:0]   req_ren,
  input  logic [NREQ*AW-1:0] req_addr,
  input  logic [NREQ*DW-1:0] req_store,
  output logic [NREQ-1:0]   req_wait,
  output logic [DW-1:0]     req_load,
  output logic [NREQ-1:0]   grant,
  output logic              tb_active,
  output logic              ram_wen,
  output logic              ram_ren,
  output logic [AW-1:0]     ram_addr,
  output logic [DW-1:0]     ram_store,
  input  logic [DW-1:0]     ram_load,
  input  logic              ram_ready
);

  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;

  typedef enum logic [1:0] {S_IDLE, S_GRANT, S_DRAIN, S_TB} state_t;

  state_t          state_q, state_d;
  logic [IW-1:0]   ptr_q, ptr_d;
  logic [IW-1:0]   own_q, own_d;
  logic [NREQ-1:0] grant_q, grant_d;
  logic [NREQ-1:0] req;
  logic            busy, owner_req, abandon, done;
  logic [IW-1:0]   search_base;
  logic [NREQ-1:0] search_mask;
  logic            win_vld;
  logic [IW-1:0]   win_idx;
  logic [IW-1:0]   cand_idx;
  int              cand;

  function automatic logic [IW-1:0] ptr_inc(input logic [IW-1:0] i);
    if (int'(i) >= NREQ - 1) return '0;
    return i + 1'b1;
  endfunction

  assign req       = req_wen | req_ren;
  assign busy      = (state_q == S_GRANT) || (state_q == S_DRAIN);
  assign owner_req = req[own_q];
  assign abandon   = busy & ~owner_req;
  assign done      = busy & owner_req & ram_ready;

  // Winner search; the completing owner is masked so it cannot re-win this cycle.
  always_comb begin
    search_base = (state_q == S_IDLE) ? ptr_q : ptr_inc(own_q);
    search_mask = req;
    if (busy) search_mask[own_q] = 1'b0;
    win_vld  = 1'b0;
    win_idx  = '0;
    cand     = 0;
    cand_idx = '0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      cand     = (int'(search_base) + k) % NREQ;
      cand_idx = IW'(cand);
      if (search_mask[cand_idx]) begin
        win_vld = 1'b1;
        win_idx = cand_idx;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    own_d   = own_q;
    grant_d = grant_q;
    case (state_q)
      S_IDLE: begin
        if (tbCTRL) begin
          state_d = S_TB;
          grant_d = '0;
        end else if (win_vld) begin
          state_d          = S_GRANT;
          own_d            = win_idx;
          grant_d          = '0;
          grant_d[win_idx] = 1'b1;
        end
      end
      S_GRANT: begin
        if (abandon) begin
          ptr_d   = ptr_inc(own_q);
          state_d = S_IDLE;
          grant_d = '0;
        end else if (ram_ready) begin
          if (tbCTRL) begin
            state_d = S_TB;
            grant_d = '0;
          end else begin
            ptr_d   = ptr_inc(own_q);
            grant_d = '0;
            if (win_vld) begin
              state_d          = S_GRANT;
              own_d            = win_idx;
              grant_d[win_idx] = 1'b1;
            end else begin
              state_d = S_IDLE;
            end
          end
        end else if (tbCTRL) begin
          state_d = S_DRAIN;
        end
      end
      S_DRAIN: begin
        if (abandon) begin
          ptr_d   = ptr_inc(own_q);
          state_d = S_IDLE;
          grant_d = '0;
        end else if (ram_ready) begin
          state_d = S_TB;
          grant_d = '0;
        end
      end
      S_TB: begin
        grant_d = '0;
        if (!tbCTRL) state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
        grant_d = '0;
      end
    endcase
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q <= S_IDLE;
      ptr_q   <= '0;
      own_q   <= '0;
      grant_q <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      own_q   <= own_d;
      grant_q <= grant_d;
    end
  end

  // An abandoning owner has already left, so the port is quiet that cycle.
  always_comb begin
    ram_wen   = 1'b0;
    ram_ren   = 1'b0;
    ram_addr  = '0;
    ram_store = '0;
    if (state_q == S_TB) begin
      ram_wen   = tb_wen;
      ram_ren   = tb_ren;
      ram_addr  = tb_addr;
      ram_store = tb_store;
    end else if (busy && !abandon) begin
      ram_wen   = req_wen[own_q];
      ram_ren   = req_ren[own_q] & ~req_wen[own_q];
      ram_addr  = req_addr[int'(own_q)*AW +: AW];
      ram_store = req_store[int'(own_q)*DW +: DW];
    end
  end

  assign req_wait  = req & ~(grant_q & {NREQ{done}});
  assign req_load  = ram_load;
  assign grant     = grant_q;
  assign tb_active = (state_q == S_TB);

endmodule
